// File: rtl/fifo_salida_arb.sv
// Synchronous FIFO buffering one output lane of the 4-way arbiter.
// Registered pop/valid read port; status flags decoded from the occupancy count.
module fifo_salida_arb #(
    parameter int WORD_SIZE = 12,
    parameter int PTR_SIZE  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 pop,
    input  logic [PTR_SIZE:0]    umbral_af,
    input  logic [PTR_SIZE:0]    umbral_ae,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 error
);

    localparam int DEPTH = 1 << PTR_SIZE;
    localparam logic [PTR_SIZE:0]   FULL_CNT = {1'b1, {PTR_SIZE{1'b0}}};
    localparam logic [PTR_SIZE:0]   CNT_ONE  = {{PTR_SIZE{1'b0}}, 1'b1};
    localparam logic [PTR_SIZE-1:0] PTR_ONE  = {{(PTR_SIZE-1){1'b0}}, 1'b1};

    logic [WORD_SIZE-1:0] mem [DEPTH];
    logic [PTR_SIZE-1:0]  wr_ptr;
    logic [PTR_SIZE-1:0]  rd_ptr;
    logic [PTR_SIZE:0]    count;
    logic                 push_ok;
    logic                 pop_ok;

    // A pop on a full FIFO frees a slot in the same cycle, so the push is still taken.
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != FULL_CNT) || pop_ok);

    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == FULL_CNT);
    assign almost_full  = (count >= umbral_af);
    assign almost_empty = (count <= umbral_ae);

    // NOTE: the storage array has no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            error     <= 1'b0;
        end else begin
            valid_out <= pop_ok;
            if (pop_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_ONE;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // Sticky until reset: any dropped push or empty pop.
            if ((push && !push_ok) || (pop && !pop_ok)) begin
                error <= 1'b1;
            end
        end
    end

endmodule
